tt_regbank_fifo: RTL and testbench
==================================

# tt_regbank_fifo

Parametrised successor to the fixed 4-word by 4-bit user register file. It is a DEPTH by WIDTH register bank with two run-time modes:

- **RAM mode:** addressed write and combinational addressed read, the same behaviour as the fixed block.
- **FIFO mode:** push/pop queue with full/empty flags, occupancy count and sticky error flags.

It sits directly behind the TinyTapeout user IO wrapper. It also serves as a reusable scratch store for other user modules.

## Interface
Parameters:
- WIDTH, 4, data word width in bits (1..16).
- DEPTH, 4, number of words; power of two, 2..16.
- AW, $clog2(DEPTH), derived address/pointer width; not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  0 = RAM, 1 = FIFO.
- clear  in  1  synchronous clear of pointers, count and error flags; storage is untouched.
- addr  in  AW  RAM-mode read/write address.
- we  in  1  RAM-mode write enable.
- wdata  in  WIDTH  write/push data.
- push  in  1  FIFO-mode push request.
- pop  in  1  FIFO-mode pop request.
- rdata  out  WIDTH  RAM: mem[addr]; FIFO: head word, or 0 when empty.
- full  out  1  FIFO count == DEPTH (always 0 in RAM mode).
- empty  out  1  FIFO count == 0 (always 1 in RAM mode).
- count  out  AW+1  FIFO occupancy (always 0 in RAM mode).
- ovf  out  1  sticky: a push was rejected.
- udf  out  1  sticky: a pop was rejected.

## Operation
- **Reset (rst_n low):**
  - All storage words, wr_ptr, rd_ptr, count, ovf, udf and mode_q are 0 asynchronously.
  - Outputs: rdata=0, full=0, empty=1, count=0, ovf=0, udf=0.
- **mode_q:**
  - Registered copy of mode.
  - On any edge where mode != mode_q: wr_ptr, rd_ptr, count, ovf and udf go to 0, and mode_q updates. Storage is preserved.
  - All other inputs are ignored that cycle.
  - Behaviour below uses mode_q.
- **clear:** highest priority after reset and the mode change; same effect as a mode change without altering mode_q.
- **RAM mode:**
  - we=1 writes wdata to mem[addr] on the edge.
  - push and pop are ignored and do not set flags.
- **FIFO mode:**
  - we and addr are ignored.
  - Accepted push: writes mem[wr_ptr]; wr_ptr = wr_ptr+1 mod DEPTH.
  - Accepted pop: rd_ptr = rd_ptr+1 mod DEPTH.
  - count: +1 on push only, -1 on pop only, unchanged on both.
- **Acceptance rules:**
  - Push is accepted if not full, or if full with a simultaneous pop. Full with push+pop: both are accepted and count stays at DEPTH.
  - Pop is accepted if not empty. Empty with push+pop: push is accepted, pop is rejected, udf is set and count becomes 1.
  - Push while full without pop: rejected, ovf set, no state change.
  - Pop while empty: rejected, udf set.
- **Flags:** ovf and udf stay set until clear, a mode change or reset.

## Timing
- Writes and pushes take effect at the rising edge.
- rdata is a combinational read of storage and pointers. A written or pushed value is visible on rdata the cycle after the edge; there is no bypass of wdata onto rdata.
- full, empty and count are decoded from the registered count, valid the cycle after the causing edge.
- ovf and udf assert the cycle after the offending edge.
- Zero-cycle read latency; one-cycle write latency; throughput of one push and one pop per cycle.
- Pointer wrap is modulo DEPTH; count never exceeds DEPTH and never underflows.
- Reset asserted mid-operation clears everything immediately, independent of clk. Deassertion is synchronised externally.

## Structure
- Package tt_regbank_pkg:
  - MODE_RAM=1'b0, MODE_FIFO=1'b1.
  - Default WIDTH/DEPTH localparams.
- Sub-module tt_regbank_storage:
  - DEPTH by WIDTH flop array with async reset to 0.
  - One write port (en, waddr, wdata) and one combinational read port (raddr, rdata).
  - The top muxes waddr/raddr between addr and the pointers by mode_q.
- The top holds mode_q, the pointers, count, the acceptance logic and the flags.

## Test plan
- **Reset and RAM read/write:** reset, then RAM-mode writes 0x1,0x2,0x3,0x4 to addrs 0..3 → reads give 0x1..0x4; a read before writes gives 0; empty=1, count=0.
- **FIFO fill/drain:** DEPTH=4, mode=1, push 0xA,0xB,0xC,0xD.
  - Expect count=4, full=1, rdata=0xA.
  - A 5th push sets ovf=1 and leaves rdata=0xA.
  - Four pops return 0xA..0xD in order, then empty=1 and rdata=0.
- **Simultaneous push+pop:**
  - When full: count stays 4, the head advances, the new word is read last, and ovf=0.
  - When empty: count=1, udf=1, and rdata is the pushed word next cycle.
- **Wrap-around:** 10 interleaved push/pop pairs with count held at 2 → data order is preserved across three pointer wraps; full is never asserted.
- **Mode switch and clear:**
  - FIFO holding 3 words, switch to RAM → count=0 and flags cleared; RAM reads at addrs 0..2 return the pushed words.
  - clear in FIFO mode → empty=1 and ovf=udf=0.
- **Async reset mid-stream:** assert rst_n low between edges during pushes → all outputs reach their reset values before the next edge; storage reads back 0.

Source files
------------

// File: rtl/tt_regbank_pkg.sv
// Shared types and defaults for the register-bank / FIFO block.
package tt_regbank_pkg;

    typedef enum logic {
        MODE_RAM  = 1'b0,
        MODE_FIFO = 1'b1
    } mode_e;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/tt_regbank_fifo_if.sv
// Control/data bundle between the user IO wrapper (master) and the bank (slave).
interface tt_regbank_fifo_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int AW = $clog2(DEPTH);

    logic             mode;
    logic             clear;
    logic [AW-1:0]    addr;
    logic             we;
    logic [WIDTH-1:0] wdata;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rdata;
    logic             full;
    logic             empty;
    logic [AW:0]      count;
    logic             ovf;
    logic             udf;

    modport master (
        output mode, clear, addr, we, wdata, push, pop,
        input  rdata, full, empty, count, ovf, udf
    );

    modport slave (
        input  mode, clear, addr, we, wdata, push, pop,
        output rdata, full, empty, count, ovf, udf
    );

endinterface

// File: rtl/tt_regbank_storage.sv
// DEPTH x WIDTH flop array: one synchronous write port, one combinational read port.
module tt_regbank_storage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (en_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/tt_regbank_fifo.sv
// Register bank usable as addressed RAM or as a FIFO with occupancy and sticky error flags.
module tt_regbank_fifo
    import tt_regbank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst_n,
    tt_regbank_fifo_if.slave  bus
);

    localparam logic [AW:0] CNT_MAX = (AW+1)'(DEPTH);

    mode_e            mode_q, mode_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic             fifo_w, full_w, empty_w, restart_w;
    logic             push_ok_w, pop_ok_w, mem_we_w;
    logic [AW-1:0]    waddr_w, raddr_w;
    logic [WIDTH-1:0] mem_rdata_w;

    assign fifo_w    = (mode_q == MODE_FIFO);
    assign full_w    = (count_q == CNT_MAX);
    assign empty_w   = (count_q == '0);
    // A mode change or clear swallows every other request on that edge.
    assign restart_w = (mode_e'(bus.mode) != mode_q) || bus.clear;

    assign push_ok_w = fifo_w && !restart_w && bus.push && (!full_w || bus.pop);
    assign pop_ok_w  = fifo_w && !restart_w && bus.pop && !empty_w;
    assign mem_we_w  = !restart_w && (fifo_w ? push_ok_w : bus.we);

    assign waddr_w = fifo_w ? wr_ptr_q : bus.addr;
    assign raddr_w = fifo_w ? rd_ptr_q : bus.addr;

    always_comb begin
        mode_d   = mode_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (restart_w) begin
            mode_d   = mode_e'(bus.mode);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else if (fifo_w) begin
            if (push_ok_w) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok_w)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_ok_w && !pop_ok_w) count_d = count_q + (AW+1)'(1);
            if (pop_ok_w && !push_ok_w) count_d = count_q - (AW+1)'(1);
            if (bus.push && !push_ok_w) ovf_d = 1'b1;
            if (bus.pop && !pop_ok_w)   udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_RAM;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    tt_regbank_storage #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (mem_we_w),
        .waddr_i (waddr_w),
        .wdata_i (bus.wdata),
        .raddr_i (raddr_w),
        .rdata_o (mem_rdata_w)
    );

    assign bus.rdata = (fifo_w && empty_w) ? '0 : mem_rdata_w;
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;
    assign bus.udf   = udf_q;

endmodule

// File: tb/tb_tt_regbank_fifo.sv
// Directed bench for tt_regbank_fifo (WIDTH=4, DEPTH=4) with a queue-based scoreboard.
module tb_tt_regbank_fifo;

    typedef struct {
        string      name;
        logic [3:0] rdata;
        logic       full;
        logic       empty;
        logic [2:0] count;
        logic       ovf;
        logic       udf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    logic [3:0] mq[$];

    tt_regbank_fifo_if #(.WIDTH(4), .DEPTH(4)) bus ();

    tt_regbank_fifo #(.WIDTH(4), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string fld, input logic [15:0] act, input logic [15:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, fld, act, expv);
        end
    endtask

    // Outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.name, "rdata", {12'h0, bus.rdata}, {12'h0, e.rdata});
            chk(e.name, "full",  {15'h0, bus.full},  {15'h0, e.full});
            chk(e.name, "empty", {15'h0, bus.empty}, {15'h0, e.empty});
            chk(e.name, "count", {13'h0, bus.count}, {13'h0, e.count});
            chk(e.name, "ovf",   {15'h0, bus.ovf},   {15'h0, e.ovf});
            chk(e.name, "udf",   {15'h0, bus.udf},   {15'h0, e.udf});
        end
    end

    task automatic drv(input logic m, input logic clr, input logic [1:0] a, input logic w,
                       input logic [3:0] d, input logic ps, input logic pp);
        bus.mode  = m;
        bus.clear = clr;
        bus.addr  = a;
        bus.we    = w;
        bus.wdata = d;
        bus.push  = ps;
        bus.pop   = pp;
    endtask

    task automatic ex(input string n, input logic [3:0] rd, input logic fu, input logic em,
                      input logic [2:0] c, input logic ov, input logic ud);
        exp_t e;
        e.name = n; e.rdata = rd; e.full = fu; e.empty = em;
        e.count = c; e.ovf = ov; e.udf = ud;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] d;
        logic [3:0] sw_vals [3];
        sw_vals[0] = 4'h3; sw_vals[1] = 4'h5; sw_vals[2] = 4'h9;

        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        ex("reset", 4'h0, 0, 1, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;

        // RAM mode
        ex("ram_pre", 4'h0, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 2'(i), 1, 4'(i + 1), 0, 0);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 2'(i), 0, 0, 0, 0);
            ex("ram_rd", 4'(i + 1), 0, 1, 0, 0, 0);
            tick();
        end
        drv(0, 0, 2, 0, 4'hF, 1, 1);
        tick();
        drv(0, 0, 2, 0, 0, 0, 0);
        ex("ram_pushpop_ign", 4'h3, 0, 1, 0, 0, 0);
        tick();

        // FIFO fill / overflow / drain
        drv(1, 0, 0, 0, 0, 0, 0);
        tick();
        ex("fifo_empty", 4'h0, 0, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 4'(10 + i), 1, 0);
            tick();
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("fill", 4'hA, 1, 0, 4, 0, 0);
        tick();
        drv(1, 0, 0, 0, 4'hE, 1, 0);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("ovf", 4'hA, 1, 0, 4, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 0, 1);
            ex("drain", 4'(10 + i), (i == 0), 0, 3'(4 - i), 1, 0);
            tick();
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("drained", 4'h0, 0, 1, 0, 1, 0);
        tick();
        drv(1, 1, 0, 0, 0, 0, 0);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("clear", 4'h0, 0, 1, 0, 0, 0);
        tick();

        // Simultaneous push+pop when full, then when empty
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 4'(i + 1), 1, 0);
            tick();
        end
        drv(1, 0, 0, 0, 4'h5, 1, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("full_pp", 4'h2, 1, 0, 4, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 0, 0, 0, 0, 1);
            ex("full_pp_drain", 4'(2 + i), (i == 0), 0, 3'(4 - i), 0, 0);
            tick();
        end
        drv(1, 0, 0, 0, 4'h6, 1, 1);
        tick();
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("empty_pp", 4'h6, 0, 0, 1, 0, 1);
        tick();
        drv(1, 1, 0, 0, 0, 0, 0);
        tick();

        // Wrap-around with occupancy held at 2
        drv(1, 0, 0, 0, 4'h7, 1, 0); tick();
        drv(1, 0, 0, 0, 4'h8, 1, 0); tick();
        mq = '{4'h7, 4'h8};
        for (int k = 0; k < 10; k++) begin
            d = 4'(9 + k);
            drv(1, 0, 0, 0, d, 1, 1);
            ex("wrap", mq[0], 0, 0, 2, 0, 0);
            tick();
            void'(mq.pop_front());
            mq.push_back(d);
        end
        for (int i = 0; i < 2; i++) begin
            drv(1, 0, 0, 0, 0, 0, 1);
            ex("wrap_drain", mq[0], 0, 0, 3'(2 - i), 0, 0);
            tick();
            void'(mq.pop_front());
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("wrap_empty", 4'h0, 0, 1, 0, 0, 0);
        tick();

        // Mode switch preserves storage and clears flags
        drv(1, 1, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 0, 0, 1); tick();
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 0, 0, sw_vals[i], 1, 0);
            tick();
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        ex("pre_switch", 4'h3, 0, 0, 3, 0, 1);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 2'(i), 0, 0, 0, 0);
            ex("switch_rd", sw_vals[i], 0, 1, 0, 0, 0);
            tick();
        end

        // Asynchronous reset in the middle of a push stream
        drv(1, 0, 0, 0, 0, 0, 0); tick();
        drv(1, 0, 0, 0, 4'hA, 1, 0); tick();
        drv(1, 0, 0, 0, 4'hB, 1, 0);
        ex("pre_rst", 4'hA, 0, 0, 1, 0, 0);
        tick();
        drv(1, 0, 0, 0, 4'hC, 1, 0);
        #2 rst_n = 1'b0;
        #1 ex("rst_mid", 4'h0, 0, 1, 0, 0, 0);
        tick();
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(0, 0, 2'(i), 0, 0, 0, 0);
            ex("rst_mem", 4'h0, 0, 1, 0, 0, 0);
            tick();
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
